// File: rtl/plot_sink_framebuffer_if.sv
// Plot command channel from the game datapath into the framebuffer sink.
// The master drives a command; the slave accepts it when in_valid && in_ready.
interface plot_sink_framebuffer_if #(
  parameter int COLOUR_W = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_x;
  logic [6:0]          in_y;
  logic [COLOUR_W-1:0] in_colour;

  modport master (output in_valid, in_x, in_y, in_colour, input in_ready);
  modport slave  (input in_valid, in_x, in_y, in_colour, output in_ready);
endinterface

// File: rtl/plot_sink_framebuffer.sv
// Plot command sink: FIFO-buffered writes into a dual-port framebuffer, full-screen clear,
// and a free-running raster scan-out with horizontal/vertical blanking.
module plot_sink_framebuffer #(
  parameter int                  H_RES      = 160,
  parameter int                  V_RES      = 120,
  parameter int                  COLOUR_W   = 3,
  parameter int                  FIFO_DEPTH = 4,
  parameter int                  PIX_DIV    = 4,
  parameter int                  H_BLANK    = 40,
  parameter int                  V_BLANK    = 5,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = '0
) (
  input  logic                          clock,
  input  logic                          resetn,
  plot_sink_framebuffer_if.slave        plot,
  input  logic                          clear_req,
  output logic                          busy,
  output logic                          drop_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                          pix_valid,
  output logic [7:0]                    pix_x,
  output logic [6:0]                    pix_y,
  output logic [COLOUR_W-1:0]           pix_colour,
  output logic                          frame_start
);
  localparam int NPIX   = H_RES * V_RES;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int H_TOT  = H_RES + H_BLANK;
  localparam int V_TOT  = V_RES + V_BLANK;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int DW     = $clog2(PIX_DIV);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = PW + 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;
  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
  } cmd_t;

  state_t              state_q, state_d;
  logic                live_q, live_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                drop_err_q, drop_err_d;
  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic                s1_valid_q, s1_valid_d;
  logic [7:0]          s1_x_q, s1_x_d;
  logic [6:0]          s1_y_q, s1_y_d;
  logic                pix_valid_q, pix_valid_d;
  logic [7:0]          pix_x_q, pix_x_d;
  logic [6:0]          pix_y_q, pix_y_d;
  logic [COLOUR_W-1:0] pix_colour_q, pix_colour_d;
  logic                frame_start_q, frame_start_d;

  cmd_t                fifo_mem [FIFO_DEPTH];
  logic [COLOUR_W-1:0] fb_mem   [NPIX];
  logic [COLOUR_W-1:0] rd_data_q;

  logic                fifo_empty, fifo_full, push, pop, head_ok;
  cmd_t                head;
  logic [ADDR_W-1:0]   head_addr, wr_addr, rd_addr;
  logic [COLOUR_W-1:0] wr_data;
  logic                wr_en, tick, rd_en;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PW{1'b0}}});
  // in_ready looks only at the current fill level, so a same-cycle pop never frees a slot.
  assign plot.in_ready = live_q && (state_q == S_IDLE) && !fifo_full;
  assign push       = plot.in_valid && plot.in_ready;
  assign pop        = !fifo_empty && (state_q != S_CLEAR);
  assign head       = fifo_mem[rd_ptr_q[PW-1:0]];
  assign head_ok    = (32'(head.x) < H_RES) && (32'(head.y) < V_RES);
  assign head_addr  = ADDR_W'(32'(head.y) * H_RES + 32'(head.x));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    live_d     = 1'b1;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    drop_err_d = pop && !head_ok;
    wr_en      = 1'b0;
    wr_addr    = head_addr;
    wr_data    = head.colour;
    unique case (state_q)
      S_IDLE:  if (clear_req) state_d = S_DRAIN;
      S_DRAIN: begin
        clr_addr_d = '0;
        if (fifo_empty) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (32'(clr_addr_q) == NPIX - 1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = BG_COLOUR;
    end else if (pop && head_ok) begin
      wr_en = 1'b1;
    end
  end

  // Scan timing: one slot every PIX_DIV clocks; pixel appears two clocks after its slot tick.
  assign tick    = (div_q == DW'(PIX_DIV - 1));
  assign rd_en   = tick && (32'(h_q) < H_RES) && (32'(v_q) < V_RES);
  assign rd_addr = ADDR_W'(32'(v_q) * H_RES + 32'(h_q));

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (32'(h_q) == H_TOT - 1) begin
        h_d = '0;
        v_d = (32'(v_q) == V_TOT - 1) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
    s1_valid_d    = rd_en;
    s1_x_d        = 8'(h_q);
    s1_y_d        = 7'(v_q);
    pix_valid_d   = s1_valid_q;
    pix_x_d       = s1_valid_q ? s1_x_q    : pix_x_q;
    pix_y_d       = s1_valid_q ? s1_y_q    : pix_y_q;
    pix_colour_d  = s1_valid_q ? rd_data_q : pix_colour_q;
    frame_start_d = s1_valid_q && (s1_x_q == 8'd0) && (s1_y_q == 7'd0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      state_q       <= S_IDLE;
      live_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      clr_addr_q    <= '0;
      drop_err_q    <= 1'b0;
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      s1_valid_q    <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_colour_q  <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      live_q        <= live_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      clr_addr_q    <= clr_addr_d;
      drop_err_q    <= drop_err_d;
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      s1_valid_q    <= s1_valid_d;
      s1_x_q        <= s1_x_d;
      s1_y_q        <= s1_y_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_colour_q  <= pix_colour_d;
      frame_start_q <= frame_start_d;
    end
  end

  // NOTE: storage arrays have no reset so they map onto RAM; the clear command initialises pixels.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= '{x: plot.in_x, y: plot.in_y, colour: plot.in_colour};
    if (wr_en) fb_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= fb_mem[rd_addr];
  end

  assign busy        = (state_q != S_IDLE);
  assign drop_err    = drop_err_q;
  assign fifo_level  = LVL_W'(wr_ptr_q - rd_ptr_q);
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_colour  = pix_colour_q;
  assign frame_start = frame_start_q;
endmodule
